// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Shared definitions for the reg_bank_pipe register bank:
//   - RD_LAT legal range and a helper that folds RD_LAT into that range
//   - rd_stage_t: one {valid, err, data} entry of the read pipeline
//   - even_parity(): parity helper used by the optional parity protection
// No ports (package).
// -----------------------------------------------------------------------------
package reg_bank_pkg;

    // Read latency range supported by the read pipeline.
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;

    // Data field width of a pipeline stage. It is the widest register WIDTH
    // the bank supports; narrower registers are zero-extended into it and the
    // upper bits are constant zero, so synthesis removes them.
    localparam int unsigned STAGE_DW = 64;

    typedef struct packed {
        logic                valid;
        logic                err;
        logic [STAGE_DW-1:0] data;
    } rd_stage_t;

    // Even parity: the returned bit makes the total count of ones even.
    // Zero-extension of narrower data does not change the result.
    function automatic logic even_parity(input logic [STAGE_DW-1:0] d);
        return ^d;
    endfunction

    // Out-of-range latencies are folded to the nearest supported value.
    function automatic int unsigned clamp_rd_lat(input int unsigned lat);
        if (lat < RD_LAT_MIN) return RD_LAT_MIN;
        if (lat > RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/reg_bank_pipe_if.sv
// -----------------------------------------------------------------------------
// reg_bank_pipe_if
// Bus between the system controller (master) and the register bank (slave).
//   WrEn, RdEn, Address, WrData  : controller -> bank requests
//   RdData, RdD, RdErr           : pipelined read response
//   WrErr                        : one-cycle pulse for a dropped write
//   ExpRegs                      : live contents of registers 0..NUM_EXP-1
//   ParInj                       : parity fault injection, only when
//                                  REG_BANK_PARITY_EN is defined
// -----------------------------------------------------------------------------
interface reg_bank_pipe_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ADDR    = 4,
    parameter int unsigned NUM_EXP = 4
);
    logic                     WrEn;
    logic                     RdEn;
    logic [ADDR-1:0]          Address;
    logic [WIDTH-1:0]         WrData;
    logic [WIDTH-1:0]         RdData;
    logic                     RdD;
    logic                     RdErr;
    logic                     WrErr;
    logic [NUM_EXP*WIDTH-1:0] ExpRegs;

`ifdef REG_BANK_PARITY_EN
    logic                     ParInj;

    modport master (
        output WrEn, RdEn, Address, WrData, ParInj,
        input  RdData, RdD, RdErr, WrErr, ExpRegs
    );

    modport slave (
        input  WrEn, RdEn, Address, WrData, ParInj,
        output RdData, RdD, RdErr, WrErr, ExpRegs
    );
`else
    modport master (
        output WrEn, RdEn, Address, WrData,
        input  RdData, RdD, RdErr, WrErr, ExpRegs
    );

    modport slave (
        input  WrEn, RdEn, Address, WrData,
        output RdData, RdD, RdErr, WrErr, ExpRegs
    );
`endif

endinterface

// File: rtl/reg_bank_rd_pipe.sv
// -----------------------------------------------------------------------------
// reg_bank_rd_pipe
// RD_LAT-deep shift pipeline of {valid, err, data}. Stage 0 loads when a read
// is accepted; the last stage drives the response. Each stage keeps its data
// when no valid entry moves into it, so the response data holds its last
// valid value between pulses, while err is forced low whenever valid is low.
// A synchronous reset flushes every stage, dropping in-flight reads.
// Ports:
//   clk_i      clock
//   rst_ni     synchronous active-low reset
//   acc_i      read accepted this cycle
//   err_i      error flag of the accepted read
//   data_i     snapshot data of the accepted read
//   rd_d_o     response valid pulse
//   rd_err_o   response error (low when rd_d_o is low)
//   rd_data_o  response data
// -----------------------------------------------------------------------------
module reg_bank_rd_pipe
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             acc_i,
    input  logic             err_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             rd_d_o,
    output logic             rd_err_o,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int unsigned LAT = clamp_rd_lat(RD_LAT);

    rd_stage_t src    [LAT];
    rd_stage_t pipe_d [LAT];
    rd_stage_t pipe_q [LAT];

    // NOTE: every element is written on every pass before it is read, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        src[0].valid = acc_i;
        src[0].err   = err_i;
        src[0].data  = STAGE_DW'(data_i);
        for (int i = 1; i < LAT; i++) begin
            src[i] = pipe_q[i-1];
        end
        for (int i = 0; i < LAT; i++) begin
            pipe_d[i].valid = src[i].valid;
            pipe_d[i].err   = src[i].valid & src[i].err;
            pipe_d[i].data  = src[i].valid ? src[i].data : pipe_q[i].data;
        end
    end

    // NOTE: non-blocking assignments let all stages shift on the same edge
    // using the values they held before it, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign rd_d_o    = pipe_q[LAT-1].valid;
    assign rd_err_o  = pipe_q[LAT-1].err;
    assign rd_data_o = pipe_q[LAT-1].data[WIDTH-1:0];

endmodule

// File: rtl/reg_bank_pipe.sv
// -----------------------------------------------------------------------------
// reg_bank_pipe
// DEPTH x WIDTH register bank with a pipelined read path (RD_LAT cycles),
// per-register read-only protection (RO_MASK) and reset values (RST_VAL).
// Registers 0..NUM_EXP-1 are exported live on ExpRegs.
// Optional feature: define REG_BANK_PARITY_EN to add one even-parity bit per
// register, checked on reads (mismatch raises RdErr), plus the ParInj input
// that inverts the stored parity bit on writes for fault injection.
// Ports:
//   CLK   system clock
//   RST   synchronous active-low reset
//   bus   reg_bank_pipe_if.slave: WrEn, RdEn, Address, WrData, [ParInj] in;
//         RdData, RdD, RdErr, WrErr, ExpRegs out
// WIDTH is limited to reg_bank_pkg::STAGE_DW bits.
// -----------------------------------------------------------------------------
module reg_bank_pipe
    import reg_bank_pkg::*;
#(
    parameter int unsigned             WIDTH   = 8,
    parameter int unsigned             DEPTH   = 16,
    parameter int unsigned             ADDR    = 4,
    parameter int unsigned             RD_LAT  = 1,
    parameter int unsigned             NUM_EXP = 4,
    parameter logic [DEPTH*WIDTH-1:0]  RST_VAL = '0,
    parameter logic [DEPTH-1:0]        RO_MASK = '0
) (
    input  logic           CLK,
    input  logic           RST,
    reg_bank_pipe_if.slave bus
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             wr_err_q;
    logic             wr_err_d;

    logic             in_range;
    logic             ro_hit;
    logic             wr_ok;
    logic             rd_acc;
    logic             rd_err;
    logic [WIDTH-1:0] rd_word;

    // Address decode. Comparing against each index keeps out-of-range
    // addresses (DEPTH need not be a power of two) from aliasing onto a
    // real register: they simply match nothing and read as zero.
    assign in_range = 32'(bus.Address) < DEPTH;

    always_comb begin
        ro_hit  = 1'b0;
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.Address == ADDR'(i)) begin
                ro_hit  = RO_MASK[i];
                rd_word = regs_q[i];
            end
        end
    end

    assign wr_ok    = bus.WrEn & in_range & ~ro_hit;
    assign wr_err_d = bus.WrEn & ~wr_ok;
    // A simultaneous write wins; the read is dropped.
    assign rd_acc   = bus.RdEn & ~bus.WrEn;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_ok && bus.Address == ADDR'(i)) begin
                regs_d[i] = bus.WrData;
            end
        end
    end

    // NOTE: the storage is reset on purpose -- every register has a defined
    // reset value and read-only registers are nothing but that value.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= RST_VAL[i*WIDTH +: WIDTH];
            end
            wr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_err_q <= wr_err_d;
        end
    end

`ifdef REG_BANK_PARITY_EN
    logic par_q [DEPTH];
    logic par_d [DEPTH];
    logic rd_par;

    always_comb begin
        rd_par = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            par_d[i] = par_q[i];
            if (bus.Address == ADDR'(i)) begin
                rd_par = par_q[i];
                if (wr_ok) begin
                    par_d[i] = even_parity(STAGE_DW'(bus.WrData)) ^ bus.ParInj;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_q[i] <= even_parity(STAGE_DW'(RST_VAL[i*WIDTH +: WIDTH]));
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                par_q[i] <= par_d[i];
            end
        end
    end

    // Out-of-range reads see zero data and zero parity, so only the range
    // term can fire for them.
    assign rd_err = ~in_range | (even_parity(STAGE_DW'(rd_word)) != rd_par);
`else
    assign rd_err = ~in_range;
`endif

    reg_bank_rd_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .acc_i     (rd_acc),
        .err_i     (rd_err),
        .data_i    (rd_word),
        .rd_d_o    (bus.RdD),
        .rd_err_o  (bus.RdErr),
        .rd_data_o (bus.RdData)
    );

    assign bus.WrErr = wr_err_q;

    // Export is the storage itself, no extra register stage.
    always_comb begin
        bus.ExpRegs = '0;
        for (int i = 0; i < NUM_EXP; i++) begin
            bus.ExpRegs[i*WIDTH +: WIDTH] = regs_q[i];
        end
    end

endmodule

// File: tb/tb_reg_bank_pipe.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_pipe
// Self-checking bench for reg_bank_pipe configured with DEPTH=12, RD_LAT=3,
// reg3 read-only, RST_VAL reg0=81 reg2=20 reg3=3C. A table of per-cycle
// vectors gives the inputs applied before a rising edge and the outputs
// expected in the cycle after it; hand-written sequences cover the exact
// read latency and, with REG_BANK_PARITY_EN, parity fault injection.
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_reg_bank_pipe;

    localparam int unsigned          WIDTH   = 8;
    localparam int unsigned          DEPTH   = 12;
    localparam int unsigned          ADDR    = 4;
    localparam int unsigned          RD_LAT  = 3;
    localparam int unsigned          NUM_EXP = 4;
    localparam logic [DEPTH*WIDTH-1:0] RST_VAL = 96'h3C20_0081;
    localparam logic [DEPTH-1:0]     RO_MASK = 12'h008;

    localparam logic [31:0] E0 = 32'h3C20_0081;  // export after reset
    localparam logic [31:0] E1 = 32'h3C20_AA81;  // export after reg1 <= AA

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    reg_bank_pipe_if #(.WIDTH(WIDTH), .ADDR(ADDR), .NUM_EXP(NUM_EXP)) bus ();

    reg_bank_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ADDR    (ADDR),
        .RD_LAT  (RD_LAT),
        .NUM_EXP (NUM_EXP),
        .RST_VAL (RST_VAL),
        .RO_MASK (RO_MASK)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    typedef struct {
        logic        rst_n;
        logic        wr;
        logic        rd;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic        e_rdd;
        logic        e_rderr;
        logic [7:0]  e_rddata;
        logic        e_wrerr;
        logic [31:0] e_exp;
    } vec_t;

    vec_t vecs [$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst_n, input logic wr, input logic rd,
                       input logic [3:0] addr, input logic [7:0] wdata,
                       input logic e_rdd, input logic e_rderr, input logic [7:0] e_rddata,
                       input logic e_wrerr, input logic [31:0] e_exp);
        vec_t v;
        v.rst_n = rst_n; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
        v.e_rdd = e_rdd; v.e_rderr = e_rderr; v.e_rddata = e_rddata;
        v.e_wrerr = e_wrerr; v.e_exp = e_exp;
        vecs.push_back(v);
    endtask

    // Issue one read, then wait until the cycle where its response is due.
    task automatic read_wait(input logic [3:0] addr);
        bus.RdEn    = 1'b1;
        bus.Address = addr;
        @(negedge CLK);
        bus.RdEn = 1'b0;
        repeat (RD_LAT - 1) @(negedge CLK);
    endtask

    task automatic write_one(input logic [3:0] addr, input logic [7:0] data);
        bus.WrEn    = 1'b1;
        bus.Address = addr;
        bus.WrData  = data;
        @(negedge CLK);
        bus.WrEn = 1'b0;
    endtask

    initial begin
        int lat;
        logic seen;

        RST         = 1'b0;
        bus.WrEn    = 1'b0;
        bus.RdEn    = 1'b0;
        bus.Address = '0;
        bus.WrData  = '0;
`ifdef REG_BANK_PARITY_EN
        bus.ParInj  = 1'b0;
`endif

        //   rst wr rd addr  wdata  | rdd err data  wrerr exp
        // reset values, RD_LAT=3 latency
        add(1, 0, 1, 4'h0, 8'h00,    0, 0, 8'h00, 0, E0);   // 0  read r0
        add(1, 0, 1, 4'h2, 8'h00,    0, 0, 8'h00, 0, E0);   // 1  read r2
        add(1, 0, 0, 4'h0, 8'h00,    1, 0, 8'h81, 0, E0);   // 2  r0 due
        add(1, 0, 0, 4'h0, 8'h00,    1, 0, 8'h20, 0, E0);   // 3  r2 due
        add(1, 0, 0, 4'h0, 8'h00,    0, 0, 8'h20, 0, E0);   // 4  data holds
        // write then read-after-write
        add(1, 1, 0, 4'h1, 8'hAA,    0, 0, 8'h20, 0, E1);   // 5  r1<=AA
        add(1, 0, 1, 4'h1, 8'h00,    0, 0, 8'h20, 0, E1);   // 6  read r1
        add(1, 0, 0, 4'h0, 8'h00,    0, 0, 8'h20, 0, E1);   // 7
        add(1, 0, 0, 4'h0, 8'h00,    1, 0, 8'hAA, 0, E1);   // 8  AA due
        // read-only register
        add(1, 1, 0, 4'h3, 8'h55,    0, 0, 8'hAA, 1, E1);   // 9  RO write
        add(1, 0, 1, 4'h3, 8'h00,    0, 0, 8'hAA, 0, E1);   // 10 read r3
        add(1, 0, 0, 4'h0, 8'h00,    0, 0, 8'hAA, 0, E1);   // 11
        add(1, 0, 0, 4'h0, 8'h00,    1, 0, 8'h3C, 0, E1);   // 12 reset value
        // out of range (DEPTH=12)
        add(1, 0, 1, 4'hD, 8'h00,    0, 0, 8'h3C, 0, E1);   // 13 read 13
        add(1, 1, 0, 4'hD, 8'h77,    0, 0, 8'h3C, 1, E1);   // 14 write 13
        add(1, 0, 0, 4'h0, 8'h00,    1, 1, 8'h00, 0, E1);   // 15 err resp
        add(1, 0, 1, 4'h1, 8'h00,    0, 0, 8'h00, 0, E1);   // 16 read r1
        add(1, 0, 0, 4'h0, 8'h00,    0, 0, 8'h00, 0, E1);   // 17
        add(1, 0, 0, 4'h0, 8'h00,    1, 0, 8'hAA, 0, E1);   // 18 r1 intact
        // boundary: 11 is last valid, 12 first invalid
        add(1, 1, 0, 4'hB, 8'h5A,    0, 0, 8'hAA, 0, E1);   // 19 r11<=5A
        add(1, 0, 1, 4'hB, 8'h00,    0, 0, 8'hAA, 0, E1);   // 20 read 11
        add(1, 0, 1, 4'hC, 8'h00,    0, 0, 8'hAA, 0, E1);   // 21 read 12
        add(1, 0, 0, 4'h0, 8'h00,    1, 0, 8'h5A, 0, E1);   // 22
        add(1, 0, 0, 4'h0, 8'h00,    1, 1, 8'h00, 0, E1);   // 23
        add(1, 0, 0, 4'h0, 8'h00,    0, 0, 8'h00, 0, E1);   // 24 err low
        // write and read together: read dropped
        add(1, 1, 1, 4'h4, 8'h12,    0, 0, 8'h00, 0, E1);   // 25
        add(1, 0, 0, 4'h0, 8'h00,    0, 0, 8'h00, 0, E1);   // 26
        add(1, 0, 0, 4'h0, 8'h00,    0, 0, 8'h00, 0, E1);   // 27 no RdD
        add(1, 0, 1, 4'h4, 8'h00,    0, 0, 8'h00, 0, E1);   // 28 read r4
        add(1, 0, 0, 4'h0, 8'h00,    0, 0, 8'h00, 0, E1);   // 29
        add(1, 0, 0, 4'h0, 8'h00,    1, 0, 8'h12, 0, E1);   // 30
        // back-to-back reads
        add(1, 0, 1, 4'h0, 8'h00,    0, 0, 8'h12, 0, E1);   // 31
        add(1, 0, 1, 4'h1, 8'h00,    0, 0, 8'h12, 0, E1);   // 32
        add(1, 0, 1, 4'h2, 8'h00,    1, 0, 8'h81, 0, E1);   // 33
        add(1, 0, 0, 4'h0, 8'h00,    1, 0, 8'hAA, 0, E1);   // 34
        add(1, 0, 0, 4'h0, 8'h00,    1, 0, 8'h20, 0, E1);   // 35
        // back-to-back reads, reset one cycle after the last accept
        add(1, 0, 1, 4'h0, 8'h00,    0, 0, 8'h20, 0, E1);   // 36
        add(1, 0, 1, 4'h1, 8'h00,    0, 0, 8'h20, 0, E1);   // 37
        add(1, 0, 1, 4'h2, 8'h00,    1, 0, 8'h81, 0, E1);   // 38
        add(0, 0, 0, 4'h0, 8'h00,    0, 0, 8'h00, 0, E0);   // 39 reset edge
        add(1, 0, 0, 4'h0, 8'h00,    0, 0, 8'h00, 0, E0);   // 40 flushed
        add(1, 0, 0, 4'h0, 8'h00,    0, 0, 8'h00, 0, E0);   // 41 flushed

        // Reset state after two reset edges.
        repeat (2) @(negedge CLK);
        check("reset RdD",     32'(bus.RdD),     32'h0);
        check("reset RdErr",   32'(bus.RdErr),   32'h0);
        check("reset RdData",  32'(bus.RdData),  32'h0);
        check("reset WrErr",   32'(bus.WrErr),   32'h0);
        check("reset ExpRegs", bus.ExpRegs,      E0);

        foreach (vecs[i]) begin
            RST         = vecs[i].rst_n;
            bus.WrEn    = vecs[i].wr;
            bus.RdEn    = vecs[i].rd;
            bus.Address = vecs[i].addr;
            bus.WrData  = vecs[i].wdata;
            @(negedge CLK);
            check($sformatf("row%0d RdD", i),     32'(bus.RdD),    32'(vecs[i].e_rdd));
            check($sformatf("row%0d RdErr", i),   32'(bus.RdErr),  32'(vecs[i].e_rderr));
            check($sformatf("row%0d RdData", i),  32'(bus.RdData), 32'(vecs[i].e_rddata));
            check($sformatf("row%0d WrErr", i),   32'(bus.WrErr),  32'(vecs[i].e_wrerr));
            check($sformatf("row%0d ExpRegs", i), bus.ExpRegs,     vecs[i].e_exp);
        end
        RST      = 1'b1;
        bus.WrEn = 1'b0;
        bus.RdEn = 1'b0;

        // Exact latency: count falling edges from acceptance to RdD, bounded.
        bus.RdEn    = 1'b1;
        bus.Address = 4'h2;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(negedge CLK);
            bus.RdEn = 1'b0;
            lat++;
            if (bus.RdD === 1'b1) seen = 1'b1;
        end
        check("latency cycles", 32'(lat),        32'(RD_LAT));
        check("latency data",   32'(bus.RdData), 32'h20);
        @(negedge CLK);
        check("RdD pulse width", 32'(bus.RdD),   32'h0);

`ifdef REG_BANK_PARITY_EN
        // Injected parity fault: data still returned, RdErr raised.
        bus.ParInj = 1'b1;
        write_one(4'h5, 8'h0F);
        bus.ParInj = 1'b0;
        read_wait(4'h5);
        check("parity inj RdD",    32'(bus.RdD),    32'h1);
        check("parity inj RdErr",  32'(bus.RdErr),  32'h1);
        check("parity inj RdData", 32'(bus.RdData), 32'h0F);
        // Clean rewrite clears the fault.
        write_one(4'h5, 8'h0F);
        read_wait(4'h5);
        check("parity ok RdD",     32'(bus.RdD),    32'h1);
        check("parity ok RdErr",   32'(bus.RdErr),  32'h0);
`else
        // Same accesses without parity: an ordinary write and read.
        write_one(4'h5, 8'h0F);
        read_wait(4'h5);
        check("r5 RdD",    32'(bus.RdD),    32'h1);
        check("r5 RdErr",  32'(bus.RdErr),  32'h0);
        check("r5 RdData", 32'(bus.RdData), 32'h0F);
`endif

        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
